// File: rtl/rv_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes,
// datapath mux selects, instruction classes and sequencer states.
package rv_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JALR   = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MDR = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_FUNCT = 2'd1
  } alu_op_e;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_LUI     = 4'd1,
    CLS_AUIPC   = 4'd2,
    CLS_JAL     = 4'd3,
    CLS_JALR    = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_LOAD    = 4'd6,
    CLS_STORE   = 4'd7,
    CLS_OP_IMM  = 4'd8,
    CLS_OP      = 4'd9
  } inst_cls_e;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode classifier: legality, immediate format and class.
module control_decode
  import rv_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_legal,
  output imm_sel_e   o_imm_sel,
  output inst_cls_e  o_cls
);

  // Map the 7-bit opcode onto an instruction class and its immediate format
  always_comb begin
    o_legal   = 1'b1;
    o_imm_sel = IMM_I;
    o_cls     = CLS_ILLEGAL;
    case (i_opcode)
      OPC_LUI:    begin o_cls = CLS_LUI;    o_imm_sel = IMM_U; end
      OPC_AUIPC:  begin o_cls = CLS_AUIPC;  o_imm_sel = IMM_U; end
      OPC_JAL:    begin o_cls = CLS_JAL;    o_imm_sel = IMM_J; end
      OPC_JALR:   begin o_cls = CLS_JALR;   o_imm_sel = IMM_I; end
      OPC_BRANCH: begin o_cls = CLS_BRANCH; o_imm_sel = IMM_B; end
      OPC_LOAD:   begin o_cls = CLS_LOAD;   o_imm_sel = IMM_I; end
      OPC_STORE:  begin o_cls = CLS_STORE;  o_imm_sel = IMM_S; end
      OPC_OP_IMM: begin o_cls = CLS_OP_IMM; o_imm_sel = IMM_I; end
      OPC_OP:     begin o_cls = CLS_OP;     o_imm_sel = IMM_I; end
      default:    o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: walks each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK, owns the memory handshake and
// counts retired instructions. An illegal opcode parks it in TRAP.
module multicycle_control
  import rv_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             oldpc_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       wb_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             halted
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;
  logic             w_legal;
  imm_sel_e         w_imm_sel;
  inst_cls_e        w_cls;

  control_decode u_decode (
    .i_opcode  (opcode),
    .o_legal   (w_legal),
    .o_imm_sel (w_imm_sel),
    .o_cls     (w_cls)
  );

  // State register; TRAP is left only through reset
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_nxt;
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst)           r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + CNT_W'(1);
  end

  // Next-state and control outputs; reset forces every output low at once
  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_we       = 1'b0;
    oldpc_we    = 1'b0;
    mdr_we      = 1'b0;
    pc_we       = 1'b0;
    rf_we       = 1'b0;
    pc_sel      = PC_PLUS4;
    wb_sel      = WB_ALU;
    alu_a_sel   = 1'b0;
    alu_b_sel   = 1'b0;
    alu_op      = ALU_ADD;
    imm_sel     = IMM_I;
    w_retire    = 1'b0;
    halted      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we       = 1'b1;
          oldpc_we    = 1'b1;
          pc_we       = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        imm_sel     = w_imm_sel;
        w_state_nxt = w_legal ? ST_EXECUTE : ST_TRAP;
      end
      ST_EXECUTE: begin
        imm_sel     = w_imm_sel;
        w_state_nxt = ST_WRITEBACK;
        case (w_cls)
          CLS_OP: alu_op = ALU_FUNCT;
          CLS_OP_IMM: begin
            alu_b_sel = 1'b1;
            alu_op    = ALU_FUNCT;
          end
          CLS_AUIPC: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_b_sel   = 1'b1;
            w_state_nxt = ST_MEM;
          end
          CLS_BRANCH: begin
            pc_we       = branch_taken;
            pc_sel      = PC_BRANCH;
            w_retire    = 1'b1;
            w_state_nxt = ST_FETCH;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        imm_sel  = w_imm_sel;
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (w_cls == CLS_STORE);
        if (mem_ready) begin
          if (w_cls == CLS_STORE) begin
            w_retire    = 1'b1;
            w_state_nxt = ST_FETCH;
          end else begin
            mdr_we      = 1'b1;
            w_state_nxt = ST_WRITEBACK;
          end
        end
      end
      ST_WRITEBACK: begin
        imm_sel     = w_imm_sel;
        rf_we       = 1'b1;
        w_retire    = 1'b1;
        w_state_nxt = ST_FETCH;
        case (w_cls)
          CLS_LOAD: wb_sel = WB_MDR;
          CLS_LUI:  wb_sel = WB_IMM;
          CLS_JAL: begin
            wb_sel = WB_PC4;
            pc_we  = 1'b1;
            pc_sel = PC_BRANCH;
          end
          CLS_JALR: begin
            wb_sel    = WB_PC4;
            pc_we     = 1'b1;
            pc_sel    = PC_JALR;
            alu_b_sel = 1'b1;
          end
          default: ;
        endcase
      end
      ST_TRAP: halted = 1'b1;
      default: w_state_nxt = ST_FETCH;
    endcase
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_we     = 1'b0;
      oldpc_we  = 1'b0;
      mdr_we    = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      wb_sel    = WB_ALU;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      alu_op    = ALU_ADD;
      imm_sel   = IMM_I;
      w_retire  = 1'b0;
      halted    = 1'b0;
    end
  end

  assign retire  = w_retire;
  assign instret = rst ? '0 : r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Inputs change 1 ns after the
// rising edge; outputs are sampled 2 ns after the edge.
module tb_multicycle_control;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             mem_ready;
  logic             mem_req, mem_we, addr_sel;
  logic             ir_we, oldpc_we, mdr_we, pc_we, rf_we;
  logic [1:0]       pc_sel, wb_sel, alu_op;
  logic             alu_a_sel, alu_b_sel;
  logic [2:0]       imm_sel;
  logic             retire;
  logic [CNT_W-1:0] instret;
  logic             halted;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_sel     (addr_sel),
    .ir_we        (ir_we),
    .oldpc_we     (oldpc_we),
    .mdr_we       (mdr_we),
    .pc_we        (pc_we),
    .rf_we        (rf_we),
    .pc_sel       (pc_sel),
    .wb_sel       (wb_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .alu_op       (alu_op),
    .imm_sel      (imm_sel),
    .retire       (retire),
    .instret      (instret),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; opcode = OP_ADDI; branch_taken = 1'b0;
    step(); step();
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
    checks++; if (ir_we !== 1'b0) begin failures++; $display("FAIL rst_ir_we got=%b want=0", ir_we); end
    checks++; if (instret !== '0) begin failures++; $display("FAIL rst_instret got=%0d want=0", instret); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b want=0", halted); end
    step();
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    checks++; if ({mem_req, addr_sel, mem_we, ir_we} !== 4'b1000) begin failures++; $display("FAIL rst_release_fetch got=%b want=1000", {mem_req, addr_sel, mem_we, ir_we}); end
    step();
  endtask

  task automatic test_alu_zero_wait();
    int n_rf = 0;
    for (int c = 1; c <= 8; c++) begin
      mem_ready = 1'b1;
      opcode = (c <= 4) ? OP_ADDI : OP_ADD;
      #1;
      if (rf_we) n_rf++;
      checks++; if (retire !== (c == 4 || c == 8)) begin failures++; $display("FAIL alu_retire cyc=%0d got=%b want=%b", c, retire, (c == 4 || c == 8)); end
      if (c == 1) begin
        checks++; if ({mem_req, ir_we, oldpc_we, pc_we, pc_sel} !== 6'b111100) begin failures++; $display("FAIL fetch_done got=%b want=111100", {mem_req, ir_we, oldpc_we, pc_we, pc_sel}); end
      end
      if (c == 3) begin
        checks++; if ({alu_a_sel, alu_b_sel, alu_op} !== 4'b0101) begin failures++; $display("FAIL addi_exec got=%b want=0101", {alu_a_sel, alu_b_sel, alu_op}); end
      end
      if (c == 7) begin
        checks++; if ({alu_a_sel, alu_b_sel, alu_op} !== 4'b0001) begin failures++; $display("FAIL add_exec got=%b want=0001", {alu_a_sel, alu_b_sel, alu_op}); end
      end
      if (c == 8) begin
        checks++; if (wb_sel !== 2'd0) begin failures++; $display("FAIL add_wb_sel got=%0d want=0", wb_sel); end
      end
      step();
    end
    checks++; if (n_rf != 2) begin failures++; $display("FAIL alu_rf_we_cycles got=%0d want=2", n_rf); end
    checks++; if (instret !== 32'd2) begin failures++; $display("FAIL alu_instret got=%0d want=2", instret); end
  endtask

  task automatic test_load_wait();
    int n_req = 0;
    int n_mdr = 0;
    opcode = OP_LD;
    for (int c = 1; c <= 8; c++) begin
      mem_ready = !(c >= 4 && c <= 6);
      #1;
      if (mem_req && addr_sel) n_req++;
      if (mdr_we) n_mdr++;
      if (c >= 4 && c <= 7) begin
        checks++; if ({mem_req, addr_sel, mem_we} !== 3'b110) begin failures++; $display("FAIL load_mem_hold cyc=%0d got=%b want=110", c, {mem_req, addr_sel, mem_we}); end
      end
      checks++; if (retire !== (c == 8)) begin failures++; $display("FAIL load_retire cyc=%0d got=%b want=%b", c, retire, (c == 8)); end
      if (c == 8) begin
        checks++; if ({rf_we, wb_sel} !== 3'b101) begin failures++; $display("FAIL load_wb got=%b want=101", {rf_we, wb_sel}); end
      end
      step();
    end
    checks++; if (n_req != 4) begin failures++; $display("FAIL load_req_cycles got=%0d want=4", n_req); end
    checks++; if (n_mdr != 1) begin failures++; $display("FAIL load_mdr_we got=%0d want=1", n_mdr); end
    checks++; if (instret !== 32'd3) begin failures++; $display("FAIL load_instret got=%0d want=3", instret); end
  endtask

  task automatic test_branch();
    int n_rf = 0;
    mem_ready = 1'b1;
    opcode = OP_BR;
    for (int c = 1; c <= 6; c++) begin
      branch_taken = (c >= 4);
      #1;
      if (rf_we) n_rf++;
      checks++; if (retire !== (c == 3 || c == 6)) begin failures++; $display("FAIL br_retire cyc=%0d got=%b want=%b", c, retire, (c == 3 || c == 6)); end
      if (c == 3) begin
        checks++; if ({pc_we, pc_sel} !== 3'b001) begin failures++; $display("FAIL br_not_taken got=%b want=001", {pc_we, pc_sel}); end
      end
      if (c == 4) begin
        checks++; if ({mem_req, addr_sel} !== 2'b10) begin failures++; $display("FAIL br_refetch got=%b want=10", {mem_req, addr_sel}); end
      end
      if (c == 6) begin
        checks++; if ({pc_we, pc_sel} !== 3'b101) begin failures++; $display("FAIL br_taken got=%b want=101", {pc_we, pc_sel}); end
      end
      step();
    end
    branch_taken = 1'b0;
    checks++; if (n_rf != 0) begin failures++; $display("FAIL br_rf_we got=%0d want=0", n_rf); end
    checks++; if (instret !== 32'd5) begin failures++; $display("FAIL br_instret got=%0d want=5", instret); end
  endtask

  task automatic test_store();
    mem_ready = 1'b1;
    opcode = OP_ST;
    for (int c = 1; c <= 4; c++) begin
      #1;
      if (c == 2) begin
        checks++; if (imm_sel !== 3'd1) begin failures++; $display("FAIL st_imm_sel got=%0d want=1", imm_sel); end
      end
      if (c == 4) begin
        checks++; if ({mem_req, addr_sel, mem_we, retire, rf_we} !== 5'b11110) begin failures++; $display("FAIL st_mem got=%b want=11110", {mem_req, addr_sel, mem_we, retire, rf_we}); end
      end
      step();
    end
    checks++; if (instret !== 32'd6) begin failures++; $display("FAIL st_instret got=%0d want=6", instret); end
  endtask

  task automatic test_jumps();
    mem_ready = 1'b1;
    opcode = OP_JALR;
    for (int c = 1; c <= 12; c++) begin
      opcode = (c <= 4) ? OP_JALR : ((c <= 8) ? OP_JAL : OP_LUI);
      #1;
      if (c == 4) begin
        checks++; if ({rf_we, wb_sel, pc_we, pc_sel, alu_a_sel, alu_b_sel, retire} !== 9'b1101_1001_1) begin failures++; $display("FAIL jalr_wb got=%b want=110110011", {rf_we, wb_sel, pc_we, pc_sel, alu_a_sel, alu_b_sel, retire}); end
      end
      if (c == 8) begin
        checks++; if ({rf_we, wb_sel, pc_we, pc_sel, imm_sel} !== 9'b110_1_01_100) begin failures++; $display("FAIL jal_wb got=%b want=110101100", {rf_we, wb_sel, pc_we, pc_sel, imm_sel}); end
      end
      if (c == 12) begin
        checks++; if ({rf_we, wb_sel, pc_we, imm_sel} !== 7'b111_0_011) begin failures++; $display("FAIL lui_wb got=%b want=1110011", {rf_we, wb_sel, pc_we, imm_sel}); end
      end
      step();
    end
    checks++; if (instret !== 32'd9) begin failures++; $display("FAIL jump_instret got=%0d want=9", instret); end
  endtask

  task automatic test_trap();
    int n_bad = 0;
    mem_ready = 1'b1;
    opcode = OP_BAD;
    step(); step();
    for (int c = 0; c < 20; c++) begin
      #1;
      if (mem_req !== 1'b0 || halted !== 1'b1 || retire !== 1'b0 || pc_we !== 1'b0) n_bad++;
      step();
    end
    checks++; if (n_bad != 0) begin failures++; $display("FAIL trap_hold bad_cycles=%0d want=0", n_bad); end
    checks++; if (instret !== 32'd9) begin failures++; $display("FAIL trap_instret got=%0d want=9", instret); end
    rst = 1'b1;
    step();
    rst = 1'b0; mem_ready = 1'b0; opcode = OP_ADDI;
    #1;
    checks++; if ({halted, mem_req, addr_sel} !== 3'b010) begin failures++; $display("FAIL trap_clear got=%b want=010", {halted, mem_req, addr_sel}); end
    checks++; if (instret !== '0) begin failures++; $display("FAIL trap_clear_instret got=%0d want=0", instret); end
    step();
  endtask

  task automatic test_reset_mid_fetch();
    mem_ready = 1'b1;
    opcode = OP_ADDI;
    repeat (4) step();
    checks++; if (instret !== 32'd1) begin failures++; $display("FAIL mid_pre_instret got=%0d want=1", instret); end
    mem_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if ({mem_req, addr_sel, ir_we} !== 3'b100) begin failures++; $display("FAIL mid_fetch_wait got=%b want=100", {mem_req, addr_sel, ir_we}); end
      step();
    end
    rst = 1'b1; mem_ready = 1'b1;
    step();
    #1;
    checks++; if ({mem_req, ir_we, retire} !== 3'b000) begin failures++; $display("FAIL mid_rst_outputs got=%b want=000", {mem_req, ir_we, retire}); end
    checks++; if (instret !== '0) begin failures++; $display("FAIL mid_rst_instret got=%0d want=0", instret); end
    step();
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    checks++; if ({mem_req, addr_sel, mem_we} !== 3'b100) begin failures++; $display("FAIL mid_restart got=%b want=100", {mem_req, addr_sel, mem_we}); end
    step();
  endtask

  initial begin
    rst = 1'b1; opcode = '0; branch_taken = 1'b0; mem_ready = 1'b0;
    #1;
    test_reset();
    test_alu_zero_wait();
    test_load_wait();
    test_branch();
    test_store();
    test_jumps();
    test_trap();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV32I core: a single FSM that walks each instruction through fetch, decode, execute, memory and writeback over several cycles. It drives the enables and mux selects of the shared datapath (PC, IR, old-PC, MDR, register file, ALU, unified memory port) from the instruction opcode. It sits beside the datapath, replacing per-instruction combinational control, and owns the single memory-port handshake plus a retired-instruction counter.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `opcode`  in  7: IR[6:0]. Valid from DECODE onward.
- `branch_taken`  in  1: datapath compare result for the current funct3. Valid in EXECUTE.
- `mem_ready`  in  1: memory completes the current request.
- `mem_req`  out  1: memory request.
- `mem_we`  out  1: write request; 0 means read.
- `addr_sel`  out  1: memory address select; 0 = PC, 1 = ALU result.
- `ir_we`, `oldpc_we`, `mdr_we`, `pc_we`, `rf_we`  out  1 each: register load enables.
- `pc_sel`  out  2: 0 = PC+4, 1 = oldPC+imm, 2 = (rs1+imm)&~1.
- `wb_sel`  out  2: 0 = ALU, 1 = MDR, 2 = oldPC+4, 3 = imm.
- `alu_a_sel`  out  1: 0 = rs1, 1 = oldPC.
- `alu_b_sel`  out  1: 0 = rs2, 1 = imm.
- `alu_op`  out  2: 0 = ADD, 1 = decode funct3/funct7.
- `imm_sel`  out  3: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- `retire`  out  1: one-cycle pulse when an instruction completes.
- `instret`  out  CNT_W: count of retired instructions.
- `halted`  out  1: sticky; set on an illegal opcode.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- FETCH: `mem_req`=1, `addr_sel`=0, `mem_we`=0. The state holds until `mem_ready`. In the `mem_ready` cycle, pulse `ir_we`, `oldpc_we`, and `pc_we` with `pc_sel`=0, then go to DECODE.
- DECODE: registers are read. Opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP} goes to TRAP; otherwise go to EXECUTE. `imm_sel` is driven from the opcode in DECODE through WRITEBACK.
- EXECUTE:
  - OP: `alu_a_sel`=0, `alu_b_sel`=0, `alu_op`=1.
  - OP_IMM: as OP but `alu_b_sel`=1.
  - AUIPC: a=1, b=1, `alu_op`=0.
  - LOAD/STORE: a=0, b=1, `alu_op`=0, then go to MEM.
  - BRANCH: `pc_we`=`branch_taken`, `pc_sel`=1, `retire`=1, then go to FETCH.
  - LUI, JAL, JALR, OP, OP_IMM and AUIPC go to WRITEBACK.
- MEM: `mem_req`=1, `addr_sel`=1, `mem_we`=(opcode==STORE). The state holds until `mem_ready`.
  - STORE: pulse `retire`, then go to FETCH.
  - LOAD: pulse `mdr_we`, then go to WRITEBACK.
- WRITEBACK: `rf_we`=1, `retire`=1, then go to FETCH.
  - `wb_sel`: LOAD=1, JAL/JALR=2, LUI=3, all others=0.
  - JAL also drives `pc_we`=1, `pc_sel`=1.
  - JALR also drives `pc_we`=1, `pc_sel`=2, `alu_a_sel`=0, `alu_b_sel`=1.
- TRAP: `halted`=1 and all enables are 0. TRAP is exited only by reset.
- `instret` increments by 1 on every `retire` and wraps modulo 2^CNT_W.
- `rf_we` is not gated on rd==x0; the register file ignores writes to x0.
- Outputs not listed for a state are 0.

## Timing
- Reset: state=FETCH, `instret`=0, `halted`=0. While `rst`=1, every output is forced to 0, including `mem_req`. The first request appears in the first cycle after `rst` falls.
- Reset mid-operation (including during a pending `mem_req`) takes effect at the next edge. The request drops and the in-flight instruction is not retired.
- Handshake:
  - `mem_req`, `mem_we` and `addr_sel` stay stable until the cycle in which `mem_ready`=1 is sampled.
  - `mem_ready` is ignored when `mem_req`=0.
  - Completion occurs in the same cycle as `mem_ready`.
- Cycle counts with zero-wait memory (`mem_ready` tied high): BRANCH 3, STORE 4, OP/OP_IMM/LUI/AUIPC/JAL/JALR 4, LOAD 5. Each wait cycle on either access adds 1.
- `retire` is registered-free (combinational from state). `instret` updates at the edge that ends the retiring state.

## Structure
- Shared package `rv_pkg`: opcode enum, `pc_sel`/`wb_sel`/`imm_sel`/`alu_op` encodings as typed enums, and the state enum.
- One sub-module, `control_decode`: purely combinational opcode to {legal, `imm_sel`, instruction class}.
- The FSM, handshake and counter live in `multicycle_control`.

## Test plan
- Zero-wait memory, ADDI then ADD: each takes 4 cycles, `retire` pulses at cycles 4 and 8, `instret`=2, `rf_we` is high exactly 2 cycles.
- LOAD with 3 wait cycles in MEM: `mem_req`/`addr_sel`=1 are held 4 cycles, `mdr_we` pulses once, total 8 cycles, `wb_sel`=1.
- BEQ with `branch_taken`=0, then `branch_taken`=1: `pc_we` is 0, then 1 with `pc_sel`=1. Both retire in 3 cycles with no `rf_we`.
- JALR: in WRITEBACK, `rf_we`=1, `wb_sel`=2, `pc_we`=1, `pc_sel`=2 in the same cycle.
- Opcode 7'b1111111: enters TRAP after DECODE, `halted`=1, `mem_req` stays 0 for 20 cycles, `instret` unchanged. `rst` clears it.
- `rst` asserted during a fetch wait: next cycle `mem_req`=0, `instret`=0. After release, FETCH restarts with `addr_sel`=0.
